// File: rtl/enhanced_processor_pkg.sv
// Shared types and sizing constants for the instruction loader.
package enhanced_processor_pkg;

  localparam int INST_ADDR_W = 5;
  localparam int INST_DATA_W = 16;
  localparam int INST_BYTE_W = 8;

  // CHK is only reachable when the trailer checksum is built in.
  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WRITE,
    CHK,
    DONE
  } ld_state_t;

endpackage

// File: rtl/inst_loader_word_assembler.sv
// word_assembler: byte handshake acceptance and high-first byte pairing.
// word_valid pulses in the cycle the low byte transfers; word_next is the
// completed word in that same cycle, so the caller can register it directly.
module word_assembler #(
  parameter int BYTE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  phase_hi,
  input  logic                  phase_lo,
  input  logic                  byte_valid,
  input  logic                  byte_ready,
  input  logic [BYTE_W-1:0]     byte_in,
  output logic                  xfer,
  output logic                  word_valid,
  output logic [2*BYTE_W-1:0]   word_next
);

  logic [BYTE_W-1:0] hi_q;

  assign xfer       = byte_valid && byte_ready;
  assign word_valid = xfer && phase_lo;
  assign word_next  = {hi_q, byte_in};

  // Hold the high byte until its partner arrives.
  always_ff @(posedge clk) begin
    if (!reset_n)            hi_q <= '0;
    else if (xfer && phase_hi) hi_q <= byte_in;
  end

endmodule

// File: rtl/inst_loader.sv
// inst_loader: fills the instruction memory from a valid/ready byte stream.
// Bytes pair high-first into words; each word is written one cycle after its
// low byte is accepted. All outputs are registered from the next state, so a
// reset edge suppresses any write that would otherwise have followed it.
// Optional trailer checksum: define INST_LOADER_CHECKSUM_EN.
module inst_loader
  import enhanced_processor_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DATA_W = INST_DATA_W,  // must be 2*BYTE_W
  parameter int BYTE_W = INST_BYTE_W
) (
  input  logic              clk_50MHz,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              load_done,
  output logic              checksum_err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  ld_state_t         state, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx, mem_addr_nx;
  logic [ADDR_W:0]   remain_q, remain_nx, count_sat;
  logic [DATA_W-1:0] mem_data_nx, word_next;
  logic              mem_wren_nx, xfer, word_valid, clr_start;

  // Requests beyond the memory depth saturate rather than wrap.
  assign count_sat = (word_count > DEPTH) ? DEPTH : word_count;
  assign clr_start = start && ((state == IDLE) || (state == DONE));

  word_assembler #(.BYTE_W(BYTE_W)) u_asm (
    .clk        (clk_50MHz),
    .reset_n    (reset_n),
    .phase_hi   (state == HI),
    .phase_lo   (state == LO),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_in    (byte_in),
    .xfer       (xfer),
    .word_valid (word_valid),
    .word_next  (word_next)
  );

`ifdef INST_LOADER_CHECKSUM_EN
  localparam ld_state_t LAST_ST = CHK;
  logic [BYTE_W-1:0] csum_q;
  logic              chk_err_q;

  // Fold payload bytes into a running XOR; judge the trailer byte in CHK.
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      csum_q    <= '0;
      chk_err_q <= 1'b0;
    end else if (clr_start) begin
      csum_q    <= '0;
      chk_err_q <= 1'b0;
    end else if (xfer && ((state == HI) || (state == LO))) begin
      csum_q <= csum_q ^ byte_in;
    end else if (xfer && (state == CHK)) begin
      chk_err_q <= (byte_in != csum_q);
    end
  end

  assign checksum_err = chk_err_q;
`else
  localparam ld_state_t LAST_ST = DONE;
  assign checksum_err = 1'b0;
`endif

  // Next state plus next values of the address/count and write port.
  always_comb begin
    state_nx    = state;
    addr_nx     = addr_q;
    remain_nx   = remain_q;
    mem_wren_nx = 1'b0;
    mem_addr_nx = mem_addr;
    mem_data_nx = mem_data;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          remain_nx = count_sat;
          addr_nx   = '0;
          state_nx  = (count_sat == '0) ? DONE : HI;
        end
      end
      HI:    if (xfer) state_nx = LO;
      LO: begin
        if (word_valid) begin
          state_nx    = WRITE;
          mem_wren_nx = 1'b1;
          mem_addr_nx = addr_q;
          mem_data_nx = word_next;
        end
      end
      WRITE: begin
        // After the last word the address wraps to 0 but nothing more is written.
        addr_nx   = addr_q + 1'b1;
        remain_nx = remain_q - ONE;
        state_nx  = (remain_q == ONE) ? LAST_ST : HI;
      end
      CHK:     if (xfer) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Datapath and registered outputs, all derived from the next state.
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      addr_q     <= '0;
      remain_q   <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wren   <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      byte_ready <= 1'b0;
    end else begin
      addr_q     <= addr_nx;
      remain_q   <= remain_nx;
      mem_addr   <= mem_addr_nx;
      mem_data   <= mem_data_nx;
      mem_wren   <= mem_wren_nx;
      busy       <= (state_nx == HI) || (state_nx == LO) ||
                    (state_nx == WRITE) || (state_nx == CHK);
      load_done  <= (state_nx == DONE);
      byte_ready <= (state_nx == HI) || (state_nx == LO) || (state_nx == CHK);
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader; follows INST_LOADER_CHECKSUM_EN when defined.
`timescale 1ns/1ps
module tb_inst_loader;

`ifdef INST_LOADER_CHECKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic        clk_50MHz = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, mem_wren, busy, load_done, checksum_err;
  logic [4:0]  mem_addr;
  logic [15:0] mem_data;

  int vec_cnt = 0, err_cnt = 0, cyc = 0;
  int wr_cnt = 0, ready_viol = 0, last_wr_cyc = 0, last_xfer_cyc = 0, word_xfer_cyc = 0, done_cyc = 0;
  logic [15:0] mem_img [32];
  logic [4:0]  wr_addr_q [$];
  logic [7:0]  tb_xor = '0;

  inst_loader dut (
    .clk_50MHz(clk_50MHz), .reset_n(reset_n), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .busy(busy), .load_done(load_done), .checksum_err(checksum_err)
  );

  always #10 clk_50MHz = ~clk_50MHz;
  always @(posedge clk_50MHz) cyc <= cyc + 1;

  // Memory model and handshake-legality monitor, sampled mid-cycle.
  always @(negedge clk_50MHz) begin
    if (mem_wren) begin
      mem_img[mem_addr] = mem_data;
      wr_cnt++;
      wr_addr_q.push_back(mem_addr);
      last_wr_cyc = cyc;
    end
    if (byte_ready && (mem_wren || load_done || !busy)) ready_viol++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
    $fatal(1);
  end

  task automatic clear_model();
    wr_cnt = 0; ready_viol = 0;
    wr_addr_q.delete();
    foreach (mem_img[i]) mem_img[i] = 'x;
  endtask

  task automatic do_start(input logic [5:0] cnt);
    start = 1'b1; word_count = cnt; tb_xor = '0;
    @(negedge clk_50MHz);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    bit go;
    byte_in = b;
    do begin
      byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      go = byte_valid && byte_ready;
      if (go) last_xfer_cyc = cyc;
      @(negedge clk_50MHz);
      guard++;
    end while (!go && guard < 300);
    if (!go) begin
      vec_cnt++; err_cnt++;
      $display("FAIL send_byte: byte %h not accepted, byte_ready=%b", b, byte_ready);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input bit gaps);
    send_byte(w[15:8], gaps);
    send_byte(w[7:0], gaps);
    word_xfer_cyc = last_xfer_cyc;
    tb_xor ^= w[15:8] ^ w[7:0];
  endtask

  task automatic send_trailer();
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(tb_xor, 1'b0);
`endif
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!load_done && n < budget) begin
      @(negedge clk_50MHz);
      n++;
    end
    done_cyc = cyc;
    if (!load_done) begin
      vec_cnt++; err_cnt++;
      $display("FAIL wait_done: load_done still %b after %0d cycles", load_done, budget);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_50MHz);
    vec_cnt++;
    if ({byte_ready, mem_addr, mem_data, mem_wren, busy, load_done, checksum_err} !== 26'd0) begin
      err_cnt++; $display("FAIL reset_outputs: got %h expected 0",
        {byte_ready, mem_addr, mem_data, mem_wren, busy, load_done, checksum_err});
    end
    reset_n = 1'b1;
    @(negedge clk_50MHz);
    clear_model();
    do_start(6'd2);
    send_byte(8'h11, 1'b0);
    // Low byte offered exactly as reset lands: the write must never appear.
    byte_in = 8'h22; byte_valid = 1'b1; reset_n = 1'b0;
    repeat (2) @(negedge clk_50MHz);
    vec_cnt++;
    if ({byte_ready, mem_addr, mem_data, mem_wren, busy, load_done, checksum_err} !== 26'd0) begin
      err_cnt++; $display("FAIL reset_midload_outputs: got %h expected 0",
        {byte_ready, mem_addr, mem_data, mem_wren, busy, load_done, checksum_err});
    end
    vec_cnt++;
    if (wr_cnt !== 0) begin
      err_cnt++; $display("FAIL reset_midload_writes: got %0d expected 0", wr_cnt);
    end
    byte_valid = 1'b0; reset_n = 1'b1;
    repeat (2) @(negedge clk_50MHz);
    vec_cnt++;
    if ({byte_ready, busy, load_done, mem_wren} !== 4'b0000) begin
      err_cnt++; $display("FAIL reset_idle_after: got %b expected 0000",
        {byte_ready, busy, load_done, mem_wren});
    end
  endtask

  task automatic test_single_word();
    clear_model();
    do_start(6'd1);
    vec_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL single_busy: got %b expected 1", busy); end
    send_word(16'h1234, 1'b0);
    send_trailer();
    wait_done(20);
    vec_cnt++;
    if (wr_cnt !== 1) begin err_cnt++; $display("FAIL single_count: got %0d expected 1", wr_cnt); end
    vec_cnt++;
    if (mem_img[0] !== 16'h1234) begin
      err_cnt++; $display("FAIL single_data: got %h expected 1234", mem_img[0]);
    end
    vec_cnt++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 5'd0) begin
      err_cnt++; $display("FAIL single_addr: got %0d writes, first addr %h expected 00", wr_addr_q.size(), wr_addr_q[0]);
    end
    vec_cnt++;
    if (last_wr_cyc !== word_xfer_cyc + 1) begin
      err_cnt++; $display("FAIL single_latency: write cycle %0d expected %0d", last_wr_cyc, word_xfer_cyc + 1);
    end
    vec_cnt++;
    if ({load_done, busy, mem_wren, mem_data, checksum_err} !== {3'b100, 16'h1234, 1'b0}) begin
      err_cnt++; $display("FAIL single_done: got done=%b busy=%b wren=%b data=%h err=%b expected 1 0 0 1234 0",
        load_done, busy, mem_wren, mem_data, checksum_err);
    end
  endtask

  task automatic test_full(input logic [5:0] cnt, input bit gaps);
    int c0, bad_addr = 0, bad_data = 0;
    logic [7:0] b;
    clear_model();
    do_start(cnt);
    c0 = cyc;
    for (int i = 0; i < 32; i++) begin
      b = 8'(i);
      send_word({b, b}, gaps);
    end
    send_trailer();
    wait_done(400);
    // Keep offering bytes after completion; none may be taken or written.
    byte_in = 8'hEE; byte_valid = 1'b1;
    repeat (5) @(negedge clk_50MHz);
    byte_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      b = 8'(k);
      if (wr_addr_q.size() <= k || wr_addr_q[k] !== 5'(k)) bad_addr++;
      if (mem_img[k] !== {b, b}) bad_data++;
    end
    vec_cnt++;
    if (wr_cnt !== 32) begin
      err_cnt++; $display("FAIL full_count(cnt=%0d,gaps=%0d): got %0d expected 32", cnt, gaps, wr_cnt);
    end
    vec_cnt++;
    if (bad_addr !== 0) begin
      err_cnt++; $display("FAIL full_addr_order(cnt=%0d,gaps=%0d): %0d bad addresses expected 0", cnt, gaps, bad_addr);
    end
    vec_cnt++;
    if (bad_data !== 0) begin
      err_cnt++; $display("FAIL full_image(cnt=%0d,gaps=%0d): %0d bad words expected 0", cnt, gaps, bad_data);
    end
    vec_cnt++;
    if (ready_viol !== 0) begin
      err_cnt++; $display("FAIL full_ready_legal(cnt=%0d,gaps=%0d): %0d violations expected 0", cnt, gaps, ready_viol);
    end
    vec_cnt++;
    if (checksum_err !== 1'b0) begin
      err_cnt++; $display("FAIL full_checksum(cnt=%0d,gaps=%0d): got %b expected 0", cnt, gaps, checksum_err);
    end
    if (!gaps) begin
      vec_cnt++;
      if (done_cyc - c0 !== 96 + CHK_EXTRA) begin
        err_cnt++; $display("FAIL full_rate(cnt=%0d): took %0d cycles expected %0d", cnt, done_cyc - c0, 96 + CHK_EXTRA);
      end
    end
  endtask

  task automatic test_zero_count();
    clear_model();
    do_start(6'd0);
    vec_cnt++;
    if ({load_done, busy, byte_ready} !== 3'b100) begin
      err_cnt++; $display("FAIL zero_done: got done/busy/ready=%b expected 100", {load_done, busy, byte_ready});
    end
    repeat (4) @(negedge clk_50MHz);
    vec_cnt++;
    if (wr_cnt !== 0) begin err_cnt++; $display("FAIL zero_writes: got %0d expected 0", wr_cnt); end
  endtask

  task automatic test_start_ignored();
    clear_model();
    do_start(6'd2);
    send_byte(8'hA1, 1'b0);
    byte_valid = 1'b0; start = 1'b1; word_count = 6'd5;
    @(negedge clk_50MHz);
    start = 1'b0;
    send_byte(8'hA2, 1'b0);
    tb_xor ^= 8'hA1 ^ 8'hA2;
    send_word(16'hB1B2, 1'b0);
    send_trailer();
    wait_done(40);
    vec_cnt++;
    if (wr_cnt !== 2) begin err_cnt++; $display("FAIL ignore_count: got %0d expected 2", wr_cnt); end
    vec_cnt++;
    if ({mem_img[0], mem_img[1]} !== 32'hA1A2_B1B2) begin
      err_cnt++; $display("FAIL ignore_image: got %h %h expected a1a2 b1b2", mem_img[0], mem_img[1]);
    end
  endtask

  task automatic test_checksum();
`ifdef INST_LOADER_CHECKSUM_EN
    do_start(6'd1);
    send_word(16'h1234, 1'b0);
    send_byte(8'h26, 1'b0);
    byte_valid = 1'b0;
    wait_done(20);
    vec_cnt++;
    if (checksum_err !== 1'b0) begin err_cnt++; $display("FAIL csum_good: got %b expected 0", checksum_err); end
    do_start(6'd1);
    send_word(16'h1234, 1'b0);
    send_byte(8'h27, 1'b0);
    byte_valid = 1'b0;
    wait_done(20);
    vec_cnt++;
    if (checksum_err !== 1'b1) begin err_cnt++; $display("FAIL csum_bad: got %b expected 1", checksum_err); end
    do_start(6'd0);
    vec_cnt++;
    if (checksum_err !== 1'b0) begin err_cnt++; $display("FAIL csum_clear: got %b expected 0", checksum_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full(6'd32, 1'b0);
    test_full(6'd40, 1'b0);
    test_full(6'd32, 1'b1);
    test_zero_count();
    test_start_ignored();
    test_checksum();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Program-loader front end that fills the 32-word instruction memory fetched by the processor's address counter.
- Accepts a byte stream over a valid/ready handshake and assembles bytes high-first into 16-bit words.
- Drives the memory write port (address, data, write enable).
- Flags completion so the processor may be released via run.

Parameters:
- ADDR_W, 5, instruction memory address width; depth = 2**ADDR_W.
- DATA_W, 16, instruction word width; must equal 2*BYTE_W.
- BYTE_W, 8, stream byte width.

Ports:
- clk_50MHz  input  1  system clock; all logic on rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- word_count  input  ADDR_W+1  words to load, sampled with start; 0..2**ADDR_W.
- byte_in  input  BYTE_W  stream data.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  ADDR_W  write address.
- mem_data  output  DATA_W  write data.
- mem_wren  output  1  write strobe, one cycle per word.
- busy  output  1  high from the cycle after start until DONE.
- load_done  output  1  level, high in DONE until next start or reset.
- checksum_err  output  1  see Optional Feature.

Behaviour:
- Reset (reset_n low at clock edge): state IDLE; all outputs 0; address counter 0; word latch 0; remaining count 0.
- A byte transfers in any cycle with byte_valid && byte_ready.
- byte_ready is a registered function of state: high only in HI and LO (and CHK when enabled).
- States:
  - IDLE: on start, latch count = min(word_count, 2**ADDR_W), clear address to 0. Count 0 -> DONE, else -> HI.
  - HI: on transfer, latch byte_in into word[15:8] -> LO.
  - LO: on transfer, latch byte_in into word[7:0] -> WRITE.
  - WRITE: one cycle. mem_wren=1, mem_data=word, mem_addr=current address. Then increment address and decrement remaining. Remaining now 0 -> DONE (or CHK), else -> HI.
  - DONE: load_done=1, busy=0. On start, behave as IDLE start (reload).
- Latency: mem_wren asserts exactly one cycle after the low byte's transfer cycle.
- Peak rate is one word per 3 cycles.
- Address wrap: loading 32 words writes addresses 0..31; the counter wraps to 0 internally but no further write occurs.
- start in HI/LO/WRITE: ignored, no effect.
- byte_valid with byte_ready low: byte not consumed; the source must hold it.
- Reset mid-load: immediate return to IDLE. A pending WRITE is suppressed (mem_wren 0 in the reset cycle). Partially written memory is not rolled back.
- mem_addr and mem_data hold their last values outside WRITE; mem_wren is 0 outside WRITE.

Optional Feature:
- Macro INST_LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR of all payload bytes.
  - After the last WRITE, state CHK accepts one extra byte.
  - checksum_err = (byte != running XOR), registered on entry to DONE, cleared on start/reset.
- Undefined:
  - No CHK state; WRITE goes directly to DONE.
  - checksum_err tied 0.

Decomposition:
- Package enhanced_processor_pkg holds:
  - state enum (IDLE, HI, LO, WRITE, CHK, DONE);
  - constants INST_ADDR_W=5, INST_DATA_W=16, INST_BYTE_W=8.
- One sub-module, word_assembler: handshake acceptance plus the HI/LO byte latch, presenting a word_valid pulse to the top-level FSM.

Test Plan:
- Reset: hold reset_n=0 two cycles mid-load -> all outputs 0, state IDLE, no mem_wren during reset.
- Single word: start, word_count=1, bytes 0x12,0x34 back-to-back -> one mem_wren, addr 0, data 0x1234, one cycle after 0x34 accepted; load_done=1.
- Full memory: word_count=32, data word i = i*0x0101 -> 32 writes at addresses 0..31 in order, no 33rd write; word_count=40 behaves identically (saturation).
- Backpressure/gaps: byte_valid toggled randomly, byte_in held while not accepted -> same memory image as the gapless run; byte_ready never high in WRITE/IDLE/DONE.
- word_count=0 -> DONE next cycle, zero writes; start during LO -> ignored, load continues.
- With INST_LOADER_CHECKSUM_EN: payload 0x12,0x34 with trailer 0x26 -> checksum_err=0; trailer 0x27 -> checksum_err=1.
